// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit owning the HI/LO registers
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [1:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HIWrite,
    input  logic        LOWrite,
    input  logic        HIRead,
    input  logic        LORead,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] RdData
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = ($clog2(MAXC + 1) > 4) ? $clog2(MAXC + 1) : 4;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [63:0]    pend_q, pend_d;
    logic           dz_q, dz_d;
    logic [31:0]    hi_q, hi_d, lo_q, lo_d;

    logic               ovf, bz;
    logic [31:0]        db, sq, sr, uq, ur;
    logic signed [31:0] sq_raw, sr_raw;
    logic signed [63:0] ps;
    logic [63:0]        pu, res;

    // Result datapath; divisor forced to 1 on zero/overflow so the raw divide is always defined
    always_comb begin
        bz     = (B == 32'd0);
        ovf    = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        db     = (bz || ovf) ? 32'd1 : B;
        sq_raw = $signed(A) / $signed(db);
        sr_raw = $signed(A) % $signed(db);
        sq     = ovf ? 32'h8000_0000 : sq_raw;
        sr     = ovf ? 32'd0 : sr_raw;
        uq     = A / db;
        ur     = A % db;
        ps     = $signed(A) * $signed(B);
        pu     = {32'd0, A} * {32'd0, B};
        res    = MDOp[1] ? (MDOp[0] ? {ur, uq} : {sr, sq}) : (MDOp[0] ? pu : $unsigned(ps));
    end

    // Next-state: launch/mthi/mtlo only from IDLE without Req; RUN counts down and commits at cnt==1
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == IDLE) begin
            if (Start && !Req) begin
                state_d = RUN;
                pend_d  = res;
                dz_d    = MDOp[1] && bz;
                cnt_d   = MDOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end
            if (HIWrite && !Req) hi_d = A;
            if (LOWrite && !Req) lo_d = A;
        end else begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                if (!dz_q) {hi_d, lo_d} = pend_q;
            end
        end
    end

    // State registers, cleared asynchronously so an in-flight result is discarded
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy   = (state_q == RUN);
    assign HI     = hi_q;
    assign LO     = lo_q;
    assign RdData = HIRead ? hi_q : LORead ? lo_q : 32'd0;
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed self-checking bench for mdu_hilo
module tb_mdu_hilo;
    logic        clk, reset, Start, HIWrite, LOWrite, HIRead, LORead, Req, Busy;
    logic [1:0]  MDOp;
    logic [31:0] A, B, HI, LO, RdData;
    int n_cmp = 0;
    int n_err = 0;

    mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .HIWrite(HIWrite), .LOWrite(LOWrite), .HIRead(HIRead), .LORead(LORead),
        .Req(Req), .Busy(Busy), .HI(HI), .LO(LO), .RdData(RdData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Launch one op, optionally hold Req during RUN, check Busy for exactly n cycles
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic req_run);
        Start = 1'b1; MDOp = op; A = a; B = b;
        step();
        Start = 1'b0; A = 32'd0; B = 32'd0; Req = req_run;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy_hi"}, {31'd0, Busy}, 32'd1);
            step();
        end
        Req = 1'b0;
        chk({tag, "_busy_lo"}, {31'd0, Busy}, 32'd0);
    endtask

    task automatic chk_hilo(input string tag, input logic [31:0] h, input logic [31:0] l);
        chk({tag, "_hi"}, HI, h);
        chk({tag, "_lo"}, LO, l);
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; MDOp = 2'b00; A = 32'd0; B = 32'd0;
        HIWrite = 1'b0; LOWrite = 1'b0; HIRead = 1'b0; LORead = 1'b0; Req = 1'b0;
        #1;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk_hilo("rst", 32'd0, 32'd0);
        chk("rst_rd", RdData, 32'd0);
        step();
        reset = 1'b0;
        step();
        // T1 / T2 arithmetic
        run_op("mult", 2'b00, 32'hFFFF_FFFD, 32'd5, 5, 1'b0);
        chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'd2, 5, 1'b0);
        chk_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 10, 1'b0);
        chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 2'b11, 32'd7, 32'd2, 10, 1'b0);
        chk_hilo("divu", 32'd1, 32'd3);
        // T3 mthi/mtlo, divide by zero, overflow
        HIWrite = 1'b1; A = 32'h11; step();
        HIWrite = 1'b0; LOWrite = 1'b1; A = 32'h22; step();
        LOWrite = 1'b0; A = 32'd0;
        chk_hilo("mtx", 32'h11, 32'h22);
        run_op("divz", 2'b11, 32'd7, 32'd0, 10, 1'b0);
        chk_hilo("divz", 32'h11, 32'h22);
        run_op("ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0);
        chk_hilo("ovf", 32'd0, 32'h8000_0000);
        // T4 Start/HIWrite/LOWrite while Busy are ignored
        Start = 1'b1; MDOp = 2'b00; A = 32'd3; B = 32'd4; step();
        Start = 1'b1; MDOp = 2'b01; A = 32'hDEAD; B = 32'h100; HIWrite = 1'b1; LOWrite = 1'b1;
        step();
        Start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0; A = 32'd0; B = 32'd0;
        for (int i = 0; i < 4; i++) begin
            chk("busy_ign_hi", {31'd0, Busy}, 32'd1);
            step();
        end
        chk("busy_ign_lo", {31'd0, Busy}, 32'd0);
        chk_hilo("ign", 32'd0, 32'd12);
        // T5 Req blocks launch and writes but never cancels RUN
        Req = 1'b1; Start = 1'b1; MDOp = 2'b00; A = 32'd5; B = 32'd5; step();
        Start = 1'b0;
        chk("req_start", {31'd0, Busy}, 32'd0);
        step();
        chk("req_start2", {31'd0, Busy}, 32'd0);
        chk_hilo("req_start", 32'd0, 32'd12);
        HIWrite = 1'b1; LOWrite = 1'b1; A = 32'hBEEF; step();
        HIWrite = 1'b0; LOWrite = 1'b0; Req = 1'b0; A = 32'd0;
        chk_hilo("req_wr", 32'd0, 32'd12);
        run_op("req_run", 2'b00, 32'd6, 32'd7, 5, 1'b1);
        chk_hilo("req_run", 32'd0, 32'd42);
        // T6 async reset mid-RUN, then a clean op
        Start = 1'b1; MDOp = 2'b00; A = 32'd2; B = 32'd3; step();
        Start = 1'b0; step(); step();
        chk("pre_rst_busy", {31'd0, Busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, Busy}, 32'd0);
        chk_hilo("mid_rst", 32'd0, 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_busy", {31'd0, Busy}, 32'd0);
        chk_hilo("post_rst", 32'd0, 32'd0);
        run_op("after_rst", 2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 5, 1'b0);
        chk_hilo("after_rst", 32'd0, 32'd6);
        // RdData mux
        HIWrite = 1'b1; LOWrite = 1'b1; A = 32'hAAAA_5555; step();
        LOWrite = 1'b1; HIWrite = 1'b0; A = 32'h1234; step();
        LOWrite = 1'b0; A = 32'd0;
        HIRead = 1'b1; #1 chk("rd_hi", RdData, 32'hAAAA_5555);
        LORead = 1'b1; #1 chk("rd_both", RdData, 32'hAAAA_5555);
        HIRead = 1'b0; #1 chk("rd_lo", RdData, 32'h1234);
        LORead = 1'b0; #1 chk("rd_none", RdData, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
